// File: rtl/tt_sel_pkg.sv
// tt_sel_pkg: shared state encoding, address/gap widths and address helpers
// for the spine select controller.
package tt_sel_pkg;
  localparam int ADDR_W  = 9;
  localparam int GAP_W   = 4;
  localparam int ROW_MSB = 8;
  localparam int ROW_LSB = 5;
  localparam int COL_MSB = 4;
  localparam int COL_LSB = 0;
  typedef enum logic [1:0] {ST_OFF, ST_BREAK, ST_SETTLE, ST_ON} sel_state_e;
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] max);
    return (a >= max) ? '0 : a + ADDR_W'(1);
  endfunction
  function automatic logic [ADDR_W-1:0] addr_clamp(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] max);
    return (a > max) ? max : a;
  endfunction
endpackage

// File: rtl/tt_sel_sync.sv
// tt_sel_sync: STAGES-deep pin synchronizer; EDGE=1 turns o_q into a registered
// rising-edge pulse aligned with the cycle the synchronized level first goes high.
module tt_sel_sync #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= {r_q[STAGES-2:0], i_d};
  end
  if (EDGE) begin : g_edge
    logic r_rise;
    always_ff @(posedge clk) begin
      if (rst) r_rise <= 1'b0;
      else     r_rise <= r_q[STAGES-2] & ~r_q[STAGES-1];
    end
    assign o_q = r_rise;
  end else begin : g_lvl
    assign o_q = r_q[STAGES-1];
  end
endmodule

// File: rtl/tt_sel_ctrl.sv
// tt_sel_ctrl: break-before-make spine select/enable sequencer fed by async pins.
// Define TT_SEL_CTRL_DIRECT_LOAD_EN to add the load_valid/load_addr/load_ready port.
module tt_sel_ctrl
  import tt_sel_pkg::*;
#(
  parameter int ADDR_MAX    = 511,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_inc,
  input  logic              pin_clr,
  input  logic              pin_ena,
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              load_ready,
`endif
  output logic [ADDR_W-1:0] spine_sel,
  output logic              spine_ena,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] MAX = ADDR_W'(ADDR_MAX);
  localparam logic [GAP_W-1:0]  GAP = GAP_W'(GAP_CYCLES);
  sel_state_e        r_state, w_nxt;
  logic              w_inc, w_clr, w_ena, r_clr_d;
  logic              w_clr_ev, w_inc_ev, w_load_ev, w_ev;
  logic [ADDR_W-1:0] w_base, w_tgt, r_tgt, r_sel;
  logic [GAP_W-1:0]  r_gap;
  logic              r_ena, r_busy;
  tt_sel_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_inc (.clk(clk), .rst(rst), .i_d(pin_inc), .o_q(w_inc));
  tt_sel_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_clr (.clk(clk), .rst(rst), .i_d(pin_clr), .o_q(w_clr));
  tt_sel_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_ena (.clk(clk), .rst(rst), .i_d(pin_ena), .o_q(w_ena));
  // Only the first cycle of a held clear sequences; the whole hold masks other events.
  assign w_clr_ev = w_clr & ~r_clr_d;
  assign w_inc_ev = w_inc & ~w_clr;
  // A back-to-back event during BREAK builds on the address about to be applied.
  assign w_base   = (r_state == ST_BREAK) ? r_tgt : r_sel;
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
  assign load_ready = (r_state == ST_OFF) || (r_state == ST_ON);
  assign w_load_ev  = load_valid & load_ready & ~w_clr;
  assign w_tgt      = w_clr_ev ? '0 : w_load_ev ? addr_clamp(load_addr, MAX) : addr_inc(w_base, MAX);
`else
  assign w_load_ev  = 1'b0;
  assign w_tgt      = w_clr_ev ? '0 : addr_inc(w_base, MAX);
`endif
  assign w_ev = w_clr_ev | w_load_ev | w_inc_ev;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_OFF:    w_nxt = w_ev ? ST_BREAK : (w_ena && !w_clr) ? ST_SETTLE : ST_OFF;
      ST_BREAK:  w_nxt = w_ev ? ST_BREAK : ST_SETTLE;
      ST_SETTLE: w_nxt = w_ev ? ST_BREAK : (r_gap != '0) ? ST_SETTLE : (w_ena && !w_clr) ? ST_ON : ST_OFF;
      ST_ON:     w_nxt = w_ev ? ST_BREAK : w_ena ? ST_ON : ST_OFF;
      default:   w_nxt = ST_OFF;
    endcase
  end
  // The gap is loaded on entry to BREAK so the break cycle counts toward the settle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_clr_d <= 1'b0;
      r_tgt   <= '0;
      r_sel   <= '0;
      r_gap   <= '0;
      r_ena   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_clr_d <= w_clr;
      if (w_ev) r_tgt <= w_tgt;
      if (r_state == ST_BREAK) r_sel <= r_tgt;
      r_gap   <= (w_nxt == ST_BREAK || (r_state == ST_OFF && w_nxt == ST_SETTLE)) ? GAP :
                 (r_gap != '0) ? r_gap - GAP_W'(1) : r_gap;
      r_ena   <= (w_nxt == ST_ON);
      r_busy  <= (w_nxt == ST_BREAK) || (w_nxt == ST_SETTLE);
    end
  end
  assign spine_sel = {r_sel[ROW_MSB:ROW_LSB], r_sel[COL_MSB:COL_LSB]};
  assign spine_ena = r_ena;
  assign busy      = r_busy;
endmodule

// File: tb/tb_tt_sel_ctrl.sv
// tb_tt_sel_ctrl: scoreboard bench for tt_sel_ctrl; a second instance with
// ADDR_MAX=3 shares the pins and is checked for wrap and clamp behaviour.
`timescale 1ns/1ps
module tb_tt_sel_ctrl;
  logic       clk = 1'b0, rst = 1'b1, pin_inc = 1'b0, pin_clr = 1'b0, pin_ena = 1'b0;
  logic [8:0] sel_a, sel_b;
  logic       ena_a, ena_b, busy_a, busy_b;
  int         n_vec = 0, n_err = 0;
  logic [8:0] sb[$];
  logic [8:0] cur = '0, prev_sel = '0, want;
  logic       rst_q = 1'b1;
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
  logic       load_valid = 1'b0;
  logic [8:0] load_addr = '0;
  logic       rdy_a, rdy_b;
`endif

  always #5 clk = ~clk;

  tt_sel_ctrl dut_a (
    .clk(clk), .rst(rst), .pin_inc(pin_inc), .pin_clr(pin_clr), .pin_ena(pin_ena),
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
    .load_valid(load_valid), .load_addr(load_addr), .load_ready(rdy_a),
`endif
    .spine_sel(sel_a), .spine_ena(ena_a), .busy(busy_a));

  tt_sel_ctrl #(.ADDR_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .pin_inc(pin_inc), .pin_clr(pin_clr), .pin_ena(pin_ena),
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
    .load_valid(load_valid), .load_addr(load_addr), .load_ready(rdy_b),
`endif
    .spine_sel(sel_b), .spine_ena(ena_b), .busy(busy_b));

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (!rst_q && sel_a !== prev_sel) begin
      n_vec++;
      if (ena_a) begin
        n_err++;
        $display("FAIL bbm: spine_sel %0h->%0h while spine_ena=1", prev_sel, sel_a);
      end
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: spine_sel changed to %0h, no change expected", sel_a);
      end else begin
        want = sb.pop_front();
        if (sel_a !== want) begin
          n_err++;
          $display("FAIL sb_sel: spine_sel got %0h want %0h", sel_a, want);
        end
      end
    end
    prev_sel = sel_a;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pin_inc = 1'b0; pin_clr = 1'b0; pin_ena = 1'b0;
    tick(2);
    n_vec++; if (sel_a !== 9'h0) begin n_err++; $display("FAIL reset_sel: got %0h want 0", sel_a); end
    n_vec++; if (ena_a !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", ena_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    rst = 1'b0; cur = '0;
    tick(1);
  endtask

  task automatic test_enable();
    pin_ena = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      tick(1);
      n_vec++; if (ena_a !== (i >= 7)) begin n_err++; $display("FAIL en_ena[%0d]: got %b want %b", i, ena_a, i >= 7); end
      n_vec++; if (busy_a !== (i >= 2 && i <= 6)) begin n_err++; $display("FAIL en_busy[%0d]: got %b want %b", i, busy_a, i >= 2 && i <= 6); end
    end
    n_vec++; if (sel_a !== 9'h0) begin n_err++; $display("FAIL en_sel: got %0h want 0", sel_a); end
  endtask

  task automatic test_inc();
    cur = 9'h1; sb.push_back(cur);
    pin_inc = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick(1);
      if (i == 2) pin_inc = 1'b0;
      n_vec++; if (ena_a !== !(i >= 2 && i <= 6)) begin n_err++; $display("FAIL inc_ena[%0d]: got %b want %b", i, ena_a, !(i >= 2 && i <= 6)); end
      n_vec++; if (sel_a !== ((i >= 3) ? 9'h1 : 9'h0)) begin n_err++; $display("FAIL inc_sel[%0d]: got %0h want %0h", i, sel_a, (i >= 3) ? 1 : 0); end
    end
  endtask

  task automatic test_wrap();
    pin_ena = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0; cur = '0;
    tick(2);
    for (int i = 1; i <= 4; i++) begin
      cur = cur + 9'h1; sb.push_back(cur);
      pin_inc = 1'b1; tick(3);
      pin_inc = 1'b0; tick(6);
      n_vec++; if (sel_b !== 9'(i % 4)) begin n_err++; $display("FAIL wrap_sel[%0d]: got %0h want %0h", i, sel_b, i % 4); end
    end
  endtask

  task automatic test_clr_priority();
    cur = 9'h5; sb.push_back(cur);
    pin_inc = 1'b1; tick(3);
    pin_inc = 1'b0; tick(6);
    cur = 9'h0; sb.push_back(cur);
    pin_inc = 1'b1; pin_clr = 1'b1; tick(9);
    n_vec++; if (sel_a !== 9'h0) begin n_err++; $display("FAIL clr_pri: got %0h want 0", sel_a); end
    pin_inc = 1'b0; tick(3);
    for (int i = 0; i < 2; i++) begin
      pin_inc = 1'b1; tick(3);
      pin_inc = 1'b0; tick(3);
      n_vec++; if (sel_a !== 9'h0) begin n_err++; $display("FAIL clr_hold_sel[%0d]: got %0h want 0", i, sel_a); end
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL clr_hold_busy[%0d]: got %b want 0", i, busy_a); end
    end
    pin_clr = 1'b0; tick(4);
  endtask

  task automatic test_settle_restart();
    pin_ena = 1'b1; tick(8);
    n_vec++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL sr_on: got %b want 1", ena_a); end
    cur = 9'h1; sb.push_back(cur);
    cur = 9'h2; sb.push_back(cur);
    pin_inc = 1'b1; tick(1);
    pin_inc = 1'b0; tick(2);
    pin_inc = 1'b1; tick(1);
    pin_inc = 1'b0; tick(2);
    n_vec++; if (busy_a !== 1'b1 || ena_a !== 1'b0) begin n_err++; $display("FAIL sr_break: busy=%b ena=%b want 1 0", busy_a, ena_a); end
    n_vec++; if (sel_a !== 9'h1) begin n_err++; $display("FAIL sr_sel_hold: got %0h want 1", sel_a); end
    tick(1);
    n_vec++; if (sel_a !== 9'h2) begin n_err++; $display("FAIL sr_sel: got %0h want 2", sel_a); end
    tick(3);
    n_vec++; if (ena_a !== 1'b0) begin n_err++; $display("FAIL sr_gap: got %b want 0", ena_a); end
    tick(1);
    n_vec++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL sr_reon: got %b want 1", ena_a); end
  endtask

`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
  task automatic test_load();
    n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL ld_ready_on: got %b want 1", rdy_a); end
    cur = 9'h1A5; sb.push_back(cur);
    load_addr = 9'h1A5; load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    n_vec++; if (ena_a !== 1'b0 || rdy_a !== 1'b0) begin n_err++; $display("FAIL ld_break: ena=%b ready=%b want 0 0", ena_a, rdy_a); end
    tick(1);
    n_vec++; if (sel_a !== 9'h1A5) begin n_err++; $display("FAIL ld_sel: got %0h want 1a5", sel_a); end
    n_vec++; if (sel_b !== 9'h3) begin n_err++; $display("FAIL ld_clamp: got %0h want 3", sel_b); end
    tick(4);
    n_vec++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL ld_reon: got %b want 1", ena_a); end
  endtask
`endif

  task automatic test_ena_drop();
    pin_ena = 1'b0; tick(2);
    n_vec++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL drop_early: got %b want 1", ena_a); end
    tick(1);
    n_vec++; if (ena_a !== 1'b0 || busy_a !== 1'b0) begin n_err++; $display("FAIL drop_off: ena=%b busy=%b want 0 0", ena_a, busy_a); end
  endtask

  task automatic test_rst_mid();
    pin_inc = 1'b1; tick(3);
    n_vec++; if (busy_a !== 1'b1 || sel_a !== cur) begin n_err++; $display("FAIL rm_break: busy=%b sel=%0h want 1 %0h", busy_a, sel_a, cur); end
    pin_inc = 1'b0; rst = 1'b1; tick(1);
    n_vec++; if (sel_a !== 9'h0 || ena_a !== 1'b0 || busy_a !== 1'b0) begin n_err++; $display("FAIL rm_reset: sel=%0h ena=%b busy=%b want 0 0 0", sel_a, ena_a, busy_a); end
    rst = 1'b0; cur = '0; tick(6);
    n_vec++; if (sel_a !== 9'h0 || busy_a !== 1'b0) begin n_err++; $display("FAIL rm_after: sel=%0h busy=%b want 0 0", sel_a, busy_a); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_enable();
    test_inc();
    test_wrap();
    test_clr_priority();
    test_settle_restart();
`ifdef TT_SEL_CTRL_DIRECT_LOAD_EN
    test_load();
`endif
    test_ena_drop();
    test_rst_mid();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_left: %0d expected changes never seen", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
